// File: rtl/ddr_single_access_engine.sv
// Single 64-bit DDR3 read/write on the MIG app_* interface, requested by clk_usb level flags.
// Optional watchdog: define DDR_SINGLE_TIMEOUT_EN.
module ddr_single_access_engine #(
  parameter int pADDR_WIDTH     = 30,
  parameter int pDATA_WIDTH     = 64,
  parameter int pTIMEOUT_CYCLES = 4096
) (
  input  logic                     ui_clk,
  input  logic                     reset_i,
  input  logic                     ddr_single_write,
  input  logic                     ddr_single_read,
  input  logic [pADDR_WIDTH-1:0]   ddr_single_address,
  input  logic [pDATA_WIDTH-1:0]   ddr_single_write_data,
  output logic [pDATA_WIDTH-1:0]   ddr_single_read_data,
  output logic                     ddr_single_done,
  input  logic                     bulk_busy,
  output logic                     single_busy,
  output logic                     app_en,
  output logic [2:0]               app_cmd,
  output logic [pADDR_WIDTH-1:0]   app_addr,
  input  logic                     app_rdy,
  output logic                     app_wdf_wren,
  output logic                     app_wdf_end,
  output logic [pDATA_WIDTH-1:0]   app_wdf_data,
  output logic [pDATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                     app_wdf_rdy,
  input  logic [pDATA_WIDTH-1:0]   app_rd_data,
  input  logic                     app_rd_data_valid,
  output logic                     timeout_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    WR      = 3'd2,
    RD_CMD  = 3'd3,
    RD_WAIT = 3'd4,
    DONE    = 3'd5,
    CLEAR   = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic                   wr_req_p0, wr_req_p1;
  logic                   rd_req_p0, rd_req_p1;
  logic                   op_wr_q;
  logic                   en_done_q, wdf_done_q;
  logic [pADDR_WIDTH-1:0] addr_q;
  logic [pDATA_WIDTH-1:0] wdata_q;
  logic [pDATA_WIDTH-1:0] rd_data_q;
  logic                   active;

  assign active = (state_q == WR) || (state_q == RD_CMD) || (state_q == RD_WAIT);

`ifdef DDR_SINGLE_TIMEOUT_EN
  localparam int CNT_W = $clog2(pTIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt_q;
  logic             tmo_err_q;
  logic             tmo_hit;

  assign tmo_hit     = active && (tmo_cnt_q == CNT_W'(pTIMEOUT_CYCLES - 1));
  assign timeout_err = tmo_err_q;

  always_ff @(posedge ui_clk or posedge reset_i) begin
    if (reset_i) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else if (state_q == GRANT) begin
      tmo_cnt_q <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      if (active) tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
      if (tmo_hit) tmo_err_q <= 1'b1;
    end
  end
`else
  // Without the watchdog the limit has no effect; the flag is a constant 0.
  assign timeout_err = (pTIMEOUT_CYCLES < 0);
`endif

  // Request synchroniser (clk_usb levels -> ui_clk), p0 then p1
  always_ff @(posedge ui_clk or posedge reset_i) begin
    if (reset_i) begin
      wr_req_p0 <= 1'b0;
      wr_req_p1 <= 1'b0;
      rd_req_p0 <= 1'b0;
      rd_req_p1 <= 1'b0;
    end else begin
      wr_req_p0 <= ddr_single_write;
      wr_req_p1 <= wr_req_p0;
      rd_req_p0 <= ddr_single_read;
      rd_req_p1 <= rd_req_p0;
    end
  end

  // Transaction registers: op, address/data snapshot, acceptance flags, read capture
  always_ff @(posedge ui_clk or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      op_wr_q    <= 1'b0;
      en_done_q  <= 1'b0;
      wdf_done_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && (state_d == GRANT)) op_wr_q <= wr_req_p1;
      if (state_q == GRANT) begin
        addr_q     <= ddr_single_address;
        wdata_q    <= ddr_single_write_data;
        en_done_q  <= 1'b0;
        wdf_done_q <= 1'b0;
      end else if (state_q == WR) begin
        if (app_en && app_rdy) en_done_q <= 1'b1;
        if (app_wdf_wren && app_wdf_rdy) wdf_done_q <= 1'b1;
      end
      if ((state_q == RD_WAIT) && app_rd_data_valid) rd_data_q <= app_rd_data;
    end
  end

  always_comb begin
    state_d         = state_q;
    single_busy     = 1'b0;
    app_en          = 1'b0;
    app_cmd         = 3'b000;
    app_wdf_wren    = 1'b0;
    ddr_single_done = 1'b0;
    case (state_q)
      IDLE: begin
        if ((wr_req_p1 || rd_req_p1) && !bulk_busy) state_d = GRANT;
      end
      GRANT: begin
        single_busy = 1'b1;
        state_d     = op_wr_q ? WR : RD_CMD;
      end
      WR: begin
        // Command and data strobes are accepted independently, in any order.
        single_busy  = 1'b1;
        app_en       = !en_done_q;
        app_wdf_wren = !wdf_done_q;
        if ((en_done_q || app_rdy) && (wdf_done_q || app_wdf_rdy)) state_d = DONE;
      end
      RD_CMD: begin
        single_busy = 1'b1;
        app_en      = 1'b1;
        app_cmd     = 3'b001;
        if (app_rdy) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        single_busy = 1'b1;
        if (app_rd_data_valid) state_d = DONE;
      end
      DONE: begin
        ddr_single_done = 1'b1;
        state_d         = CLEAR;
      end
      CLEAR: begin
        // Wait for the requester to drop its level so it cannot re-trigger.
        if (!wr_req_p1 && !rd_req_p1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef DDR_SINGLE_TIMEOUT_EN
    if (tmo_hit) state_d = DONE;
`endif
  end

  assign app_wdf_end          = app_wdf_wren;
  assign app_wdf_mask         = '0;
  assign app_addr             = addr_q;
  assign app_wdf_data         = wdata_q;
  assign ddr_single_read_data = rd_data_q;

endmodule
